// File: rtl/nibble_serial_adder16.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder16
// Purpose  : Multi-cycle WIDTH-bit adder with carry-in. Operands are latched
//            on an accepted start and added one SLICE-bit slice per clock,
//            LSB slice first, through a single slice adder and a carry
//            register. The result is ready NS = WIDTH/SLICE cycles after
//            start, signalled by a one-cycle done pulse.
// Ports    : clk    - system clock, rising edge active
//            rst    - asynchronous active-high reset
//            start  - request, sampled only while idle
//            a, b   - operands, captured on accepted start
//            cin    - carry-in, captured on accepted start
//            busy   - high while an operation is in progress
//            done   - one-cycle pulse when sum/cout become valid
//            sum    - registered result, held until next completion
//            cout   - registered carry-out of the MSB slice
//            ovf    - (NIBBLE_ADD_SIGNED_OVF_EN only) two's-complement
//                     overflow, registered with sum
// Options  : define NIBBLE_ADD_SIGNED_OVF_EN to add the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder16 #(
  parameter int WIDTH = 16,  // must be an integer multiple of SLICE
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_ADD_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            NS     = WIDTH / SLICE;
  localparam int            KW     = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_slice_sum;   // MSB is the slice carry-out
  logic [WIDTH-1:0] w_psum_next;
  logic             w_accept;
  logic             w_last;

  // --------------------------------------------------------------------------
  // Slice adder: one SLICE-bit add per clock on slice k of the latched operands
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_sl      = r_a[r_k*SLICE +: SLICE];
    w_b_sl      = r_b[r_k*SLICE +: SLICE];
    w_slice_sum = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
    w_psum_next = r_psum;
    w_psum_next[r_k*SLICE +: SLICE] = w_slice_sum[SLICE-1:0];
  end

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_k == K_LAST);
  assign busy     = (r_state == S_RUN);

`ifdef NIBBLE_ADD_SIGNED_OVF_EN
  // Carry into the operand MSB is recovered from the MSB bit of the slice
  // sum; overflow is that carry-in XOR the carry-out of the MSB.
  logic w_msb_cin;
  logic w_ovf_next;
  assign w_msb_cin  = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_slice_sum[SLICE-1];
  assign w_ovf_next = w_msb_cin ^ w_slice_sum[SLICE];
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef NIBBLE_ADD_SIGNED_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_k     <= '0;
      end else if (r_state == S_RUN) begin
        r_psum  <= w_psum_next;
        r_carry <= w_slice_sum[SLICE];
        r_k     <= r_k + 1'b1;
        if (w_last) begin
          // Final slice: publish the assembled sum directly from the
          // next-state partial sum so no extra cycle is needed.
          sum  <= w_psum_next;
          cout <= w_slice_sum[SLICE];
          done <= 1'b1;
`ifdef NIBBLE_ADD_SIGNED_OVF_EN
          ovf  <= w_ovf_next;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire
